// File: rtl/test_nor_pipe.sv
// Pipelined bitwise-operation unit: valid/ready operand intake, selectable logic op with
// accumulator modes, STAGES-deep result pipeline with global advance, and a completion counter.
module test_nor_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           OP,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [WIDTH-1:0]     Y,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     ACC,
  output logic [CNT_WIDTH-1:0] DONE_COUNT
);

  localparam logic [2:0] OP_NOR     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_ACC_NOR = 3'd6;
  localparam logic [2:0] OP_ACC_XOR = 3'd7;

  logic [WIDTH-1:0] stage_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] done_q;

  logic             advance;
  logic             accept;
  logic             consume;
  logic             acc_op;
  logic [WIDTH-1:0] result;

  // Whole pipeline moves together whenever the output slot is empty or being drained.
  assign advance  = ~stage_valid[STAGES-1] | OUT_READY;
  assign accept   = IN_VALID & advance;
  assign consume  = stage_valid[STAGES-1] & OUT_READY;
  assign acc_op   = OP[2] & OP[1];

  assign IN_READY   = advance;
  assign Y          = stage_data[STAGES-1];
  assign OUT_VALID  = stage_valid[STAGES-1];
  assign ACC        = acc_q;
  assign DONE_COUNT = done_q;

  // Operation select; accumulator modes use the current ACC in place of B.
  always_comb begin
    result = '0;
    case (OP)
      OP_NOR:     result = ~(A | B);
      OP_OR:      result = A | B;
      OP_AND:     result = A & B;
      OP_NAND:    result = ~(A & B);
      OP_XOR:     result = A ^ B;
      OP_XNOR:    result = ~(A ^ B);
      OP_ACC_NOR: result = ~(acc_q | A);
      OP_ACC_XOR: result = acc_q ^ A;
      default:    result = '0;
    endcase
  end

  // Stage valid bits: stage 1 takes IN_VALID, the rest shift on advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid[0] <= IN_VALID;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  // Stage data: stage 1 loads only on acceptance so idle slots keep stale-but-invalid data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_data[i] <= '0;
      end
    end else if (advance) begin
      if (IN_VALID) begin
        stage_data[0] <= result;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_data[i] <= stage_data[i-1];
      end
    end
  end

  // Accumulator is written at acceptance so chained ACC ops see each predecessor immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else if (accept && acc_op) begin
      acc_q <= result;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q <= '0;
    end else if (consume) begin
      done_q <= done_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/test_nor_pipe.md
# test_nor_pipe

Parametrised, pipelined successor to the combinational 8-bit NOR test design used to exercise the place-and-route flow. Operands enter through a valid/ready handshake, a selectable bitwise operation (including NOR and accumulator modes) is computed, and the result travels through a configurable number of register stages before being presented with its own valid/ready handshake. A completion counter lets the bench's lights observe throughput. The block sits between an MCPNR_SWITCHES source and an MCPNR_LIGHTS sink inside a test top.

## Interface

Parameters:

- WIDTH, 8, operand/result width in bits (≥1)
- STAGES, 2, register stages from acceptance to output (≥1)
- CNT_WIDTH, 4, width of the completion counter (≥1)

Ports:

- CLK, input, 1, sole clock; all state updates on rising edge
- RST, input, 1, synchronous, active-high reset
- A, input, WIDTH, operand A
- B, input, WIDTH, operand B (ignored in accumulator modes)
- OP, input, 3, operation select, sampled with A/B
- IN_VALID, input, 1, operands valid
- IN_READY, output, 1, block can accept operands this cycle
- Y, output, WIDTH, result
- OUT_VALID, output, 1, Y valid
- OUT_READY, input, 1, sink accepts Y this cycle
- ACC, output, WIDTH, current accumulator value
- DONE_COUNT, output, CNT_WIDTH, number of results consumed, modulo 2^CNT_WIDTH

## Operation

- OP encoding:
  - 0: ~(A|B)
  - 1: A|B
  - 2: A&B
  - 3: ~(A&B)
  - 4: A^B
  - 5: ~(A^B)
  - 6: ACC_NOR, result = ~(ACC|A)
  - 7: ACC_XOR, result = ACC^A
- Acceptance: IN_VALID & IN_READY. The result is computed combinationally from A, B, OP and the current ACC, then loaded into stage 1 with valid=1.
- Accumulator: on acceptance with OP 6 or 7, ACC ← result in the same edge. Other OPs leave ACC unchanged. Back-to-back ACC ops chain; each sees the ACC written by the previous acceptance.
- Pipeline: STAGES registers, each holding data plus a valid bit. Y and OUT_VALID are the last stage's data and valid.
- Global advance: advance = ~OUT_VALID | OUT_READY. On advance, every stage shifts one place. Stage 1 loads the new result if IN_VALID, otherwise it loads valid=0. When advance=0, every stage holds.
- IN_READY = advance (combinational from OUT_VALID and OUT_READY; no dependency on IN_VALID).
- Bubbles are squeezed only by advance; there is no per-stage compaction.
- DONE_COUNT increments on OUT_VALID & OUT_READY and wraps from 2^CNT_WIDTH−1 to 0.
- Y is stable while OUT_VALID=1 and OUT_READY=0.

## Timing

- Reset: all stage valid bits 0, stage data 0, Y=0, OUT_VALID=0, ACC=0, DONE_COUNT=0. IN_READY=1 during and after reset, because it follows from OUT_VALID=0.
- RST has priority over everything. Any acceptance or consume in a reset cycle is discarded, and in-flight results are lost.
- Latency: a result accepted at edge n appears with OUT_VALID=1 after edge n+STAGES−1, i.e. STAGES cycles from IN_VALID presentation, provided there is no stall.
- Throughput: one result per cycle while OUT_READY=1.
- Full stall: with OUT_VALID=1 and OUT_READY=0, IN_READY=0, nothing is accepted and ACC does not change.
- Simultaneous consume and accept (OUT_VALID & OUT_READY & IN_VALID): the last stage is replaced and the new item enters stage 1 in the same edge.
- STAGES=1: the single register is both input and output stage. It still supports full throughput via the same advance rule.

## Test plan

- Reset, then WIDTH=8, STAGES=2: present A=0x0F, B=0x33, OP=0 for one cycle with OUT_READY=1 → after 2 cycles Y=0xC0 with OUT_VALID for 1 cycle, then DONE_COUNT=1.
- Sweep OP 0–5 back-to-back with A=0xA5, B=0x3C → Y sequence 0x42, 0xBD, 0x24, 0xDB, 0x99, 0x66 on consecutive cycles.
- Accumulator: from reset, OP=7 with A=0x01, then 0x02, then 0x04 → Y=0x01, 0x03, 0x07 and ACC=0x07. Next OP=6 with A=0x10 → Y=0xE8.
- Backpressure: fill with 3 items while OUT_READY=0 → IN_READY drops once OUT_VALID=1, Y is held stable and ACC is unchanged. Release OUT_READY → the items drain in order without loss or duplication.
- Wrap: CNT_WIDTH=4, consume 17 results → DONE_COUNT=1.
- Reset mid-stream: assert RST with 2 items in flight → the next cycle has OUT_VALID=0, ACC=0, DONE_COUNT=0, IN_READY=1, and no stale result ever appears.
